// File: rtl/led_pkg.sv
// led_pkg: shared definitions for the LED result driver.
//   led_mode_t : display mode encoding (DIRECT, LATCH, STRETCH, BLINK)
//   cnt_width  : bits needed to hold a counter value 0..max_val (minimum 1)
package led_pkg;

  typedef enum logic [1:0] {
    LED_MODE_DIRECT  = 2'd0,
    LED_MODE_LATCH   = 2'd1,
    LED_MODE_STRETCH = 2'd2,
    LED_MODE_BLINK   = 2'd3
  } led_mode_t;

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/led_result_driver_if.sv
// led_result_driver_if: result bus from the trading logic into the LED driver.
//   result       : result word, low NUM_LEDS bits drive the LEDs
//   result_valid : qualifies result
//   mode         : display mode (led_pkg::led_mode_t encoding)
//   clear        : clears latched and stretched state
// modport master drives the bus, modport slave is the LED driver side.
interface led_result_driver_if #(
  parameter int RESULT_W = 32
) ();

  logic [RESULT_W-1:0] result;
  logic                result_valid;
  logic [1:0]          mode;
  logic                clear;

  modport master (output result, output result_valid, output mode, output clear);
  modport slave  (input  result, input  result_valid, input  mode, input  clear);

endinterface

// File: rtl/led_channel.sv
// led_channel: one LED channel -- sticky flag, stretch counter and the
// registered output mux.
//   clk, rst_n : clock, synchronous active-low reset
//   set        : valid event on this channel's result bit
//   clr        : clear strobe (external clear or mode change)
//   mode_q     : registered display mode
//   phase      : shared blink phase
//   res_bit    : this channel's bit of the captured result
//   led        : registered LED drive
module led_channel
  import led_pkg::*;
#(
  parameter int STRETCH_CYCLES = 50_000_000
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      set,
  input  logic      clr,
  input  led_mode_t mode_q,
  input  logic      phase,
  input  logic      res_bit,
  output logic      led
);

  localparam int            CW       = cnt_width(STRETCH_CYCLES);
  localparam logic [CW-1:0] CNT_LOAD = CW'(STRETCH_CYCLES);

  logic          sticky;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sticky <= 1'b0;
      cnt    <= '0;
      led    <= 1'b0;
    end else begin
      // A new event always beats a clear arriving in the same cycle.
      if (set)      sticky <= 1'b1;
      else if (clr) sticky <= 1'b0;

      if (set)                 cnt <= CNT_LOAD;
      else if (clr)            cnt <= '0;
      else if (cnt != '0)      cnt <= cnt - 1'b1;

      // The output reflects state from the previous edge, giving one cycle
      // from the valid edge to the LED in every mode.
      case (mode_q)
        LED_MODE_DIRECT:  led <= res_bit;
        LED_MODE_LATCH:   led <= sticky;
        LED_MODE_STRETCH: led <= (cnt != '0);
        default:          led <= res_bit & phase;
      endcase
    end
  end

endmodule

// File: rtl/led_result_driver.sv
// led_result_driver: drives NUM_LEDS board LEDs from the low bits of the
// result bus in one of four display modes (direct, sticky latch, pulse
// stretch, blink), so short result events stay visible to a human.
//   clk      : system clock
//   rst_n    : synchronous active-low reset
//   bus      : result bus (slave side): result, result_valid, mode, clear
//   GPIO_LED : registered active-high LED drive
module led_result_driver
  import led_pkg::*;
#(
  parameter int RESULT_W       = 32,
  parameter int NUM_LEDS       = 8,
  parameter int STRETCH_CYCLES = 50_000_000,
  parameter int BLINK_HALF     = 25_000_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  led_result_driver_if.slave   bus,
  output logic [NUM_LEDS-1:0]  GPIO_LED
);

  localparam int            PW        = cnt_width(BLINK_HALF - 1);
  localparam logic [PW-1:0] PRESC_TOP = PW'(BLINK_HALF - 1);

  logic [NUM_LEDS-1:0] res_q;
  led_mode_t           mode_q;
  logic [PW-1:0]       presc;
  logic                phase;
  logic                mode_chg;

  assign mode_chg = (led_mode_t'(bus.mode) != mode_q);

  // Capture stage: result word, mode and free-running blink timebase.
  // The prescaler never restarts on a mode change so blink timing stays
  // continuous across modes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_q  <= '0;
      mode_q <= LED_MODE_DIRECT;
      presc  <= '0;
      phase  <= 1'b0;
    end else begin
      if (bus.result_valid) res_q <= bus.result[NUM_LEDS-1:0];
      mode_q <= led_mode_t'(bus.mode);
      if (presc == PRESC_TOP) begin
        presc <= '0;
        phase <= ~phase;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

  // Output stage: one channel per LED.
  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
    led_channel #(
      .STRETCH_CYCLES (STRETCH_CYCLES)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .set     (bus.result_valid & bus.result[i]),
      .clr     (bus.clear | mode_chg),
      .mode_q  (mode_q),
      .phase   (phase),
      .res_bit (res_q[i]),
      .led     (GPIO_LED[i])
    );
  end

  // Result bits above the LED count have no channel.
  if (NUM_LEDS < RESULT_W) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^bus.result[RESULT_W-1:NUM_LEDS];
  end

endmodule

// File: doc/led_result_driver.md
Name: led_result_driver

Overview:
- Parametrised successor to the single-bit result-to-LED connection. Drives NUM_LEDS board LEDs from the low bits of a RESULT_W-bit result word.
- Registered outputs, with four display modes: direct, sticky latch, pulse stretch and blink.
- Sits between the trading-logic result bus and the GPIO LED pins, so short or one-cycle result events remain visible to a human.

Parameters:
- RESULT_W, 32, width of the result bus.
- NUM_LEDS, 8, number of LED channels; channel i follows result[i]. Legal range 1..RESULT_W.
- STRETCH_CYCLES, 50_000_000, on-time in clk cycles for STRETCH mode. Must be ≥1.
- BLINK_HALF, 25_000_000, blink half-period in clk cycles. Must be ≥1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- result  in  RESULT_W  result word; only bits [NUM_LEDS-1:0] are used.
- result_valid  in  1  result qualifier; result is sampled only when high.
- mode  in  2  display mode: 0 DIRECT, 1 LATCH, 2 STRETCH, 3 BLINK. Sampled every cycle.
- clear  in  1  clears latched and stretched state.
- GPIO_LED  out  NUM_LEDS  LED drive, registered, active-high.

Behaviour:
- Interface: one clock; reset is synchronous and active-low (clk, rst_n).
- Reset (rst_n=0 at a clk edge) clears:
  - GPIO_LED, res_q, sticky, all stretch counters, blink prescaler and blink phase to 0;
  - mode_q to DIRECT.
  - Reset mid-operation aborts any stretch or blink immediately. LEDs are 0 in the cycle after the reset edge.
- Capture: on result_valid=1, res_q <= result[NUM_LEDS-1:0]. Otherwise res_q holds.
- GPIO_LED is a register. Latency from the result_valid edge to the LED change is 1 cycle in every mode: the LED reflects the new state on the edge after the edge that samples valid.
- DIRECT: LED[i] = res_q[i].
- LATCH:
  - sticky[i] sets on result_valid & result[i]; LED[i] = sticky[i].
  - clear resets sticky.
  - clear and a set in the same cycle: set wins, so no event is lost.
- STRETCH:
  - result_valid & result[i] loads cnt[i] with STRETCH_CYCLES. Otherwise cnt[i] decrements when nonzero.
  - LED[i] = (cnt[i] != 0), giving exactly STRETCH_CYCLES high cycles.
  - Retrigger while counting reloads the counter (extends, no gap).
  - clear zeroes cnt unless a load occurs in the same cycle; load wins.
  - Counter width is $clog2(STRETCH_CYCLES+1); there is no wrap, and decrement saturates at 0.
- BLINK:
  - A free-running prescaler counts 0..BLINK_HALF-1. At BLINK_HALF-1 it wraps to 0 and toggles phase.
  - LED[i] = res_q[i] & phase. The prescaler runs in all modes.
  - phase=0 after reset, so the first high half starts BLINK_HALF cycles after reset.
- Mode change: when mode != mode_q, in that cycle:
  - sticky and all cnt are cleared;
  - mode_q is updated;
  - res_q is kept and the blink prescaler is not reset.
  - A set or load arriving in the same cycle as a mode change is applied after the clear (it wins).
- result bits ≥ NUM_LEDS are ignored. result_valid=0 never alters sticky or cnt except through decrement or clear.

Decomposition:
- Shared package led_pkg holds:
  - LED_MODE_DIRECT/LATCH/STRETCH/BLINK as 2-bit localparams, or a typedef enum led_mode_t;
  - a function to compute the counter width.
- One natural sub-module, led_channel: per-bit sticky flag, stretch counter and output mux. It receives the shared phase, the mode, and clear/mode-change strobes.
- The top level instantiates led_channel NUM_LEDS times in a generate loop and owns res_q, mode_q, and the blink prescaler/phase.

Test Plan (bench overrides STRETCH_CYCLES=4, BLINK_HALF=3, NUM_LEDS=8):
- Reset and DIRECT:
  - hold rst_n=0 for 2 cycles → GPIO_LED=0x00;
  - release, mode=0, result=0x000000A5 with valid for 1 cycle → GPIO_LED=0xA5 one cycle later, held after valid drops;
  - result=0xFFFFFF00 valid → GPIO_LED=0x00.
- LATCH:
  - pulses 0x01 then 0x80 → GPIO_LED=0x81;
  - clear → 0x00;
  - clear and valid 0x02 in the same cycle → 0x02.
- STRETCH:
  - single valid 0x01 → LED[0] high for exactly 4 cycles;
  - retrigger at count 2 → high for 4 more cycles from the retrigger, no low gap;
  - clear mid-stretch → low next cycle.
- BLINK:
  - res_q=0x0F, mode=3 → GPIO_LED alternates 0x00/0x0F every 3 cycles, first 0x0F at cycle 3 after reset release.
- Mode change and reset mid-operation:
  - LATCH with sticky=0x81, switch to STRETCH → sticky cleared, LEDs 0x00;
  - assert rst_n=0 mid-stretch → GPIO_LED=0x00 next cycle, and after release DIRECT mode shows 0x00.
